gpio_in_reg: RTL

//  Input-direction companion to the GPIO output register: samples asynchronous GPIO pins,

---
 rtl/gpio_in_reg.sv | 111 +++++++++++
 1 files changed

// File: rtl/gpio_in_reg.sv
// GPIO input register: two-flop synchroniser, optional per-bit debounce (GPIO_DEBOUNCE_EN),
// programmable edge capture into a W1C STATUS register, and a level interrupt.
module gpio_in_reg #(
  parameter int WIDTH      = 8,
  parameter int DEB_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] gpio_in,
  input  logic [1:0]       addr,
  input  logic             we,
  input  logic             re,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             irq
);

  localparam logic [1:0] ADDR_DATA     = 2'd0;
  localparam logic [1:0] ADDR_STATUS   = 2'd1;
  localparam logic [1:0] ADDR_IRQ_EN   = 2'd2;
  localparam logic [1:0] ADDR_EDGE_SEL = 2'd3;

  logic [WIDTH-1:0] s1, s2;
  logic [WIDTH-1:0] lvl_q, lvl_d;
  logic [WIDTH-1:0] status_q, irq_en_q, edge_sel_q;
  logic [WIDTH-1:0] set_evt, clr_mask, rd_mux;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= gpio_in;
      s2 <= s1;
    end
  end

`ifdef GPIO_DEBOUNCE_EN
  localparam int CW = $clog2(DEB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  logic [CW-1:0] cnt_q [WIDTH];
  logic [CW-1:0] cnt_d [WIDTH];

  // A new level is accepted only after DEB_CYCLES consecutive differing edges.
  always_comb begin
    lvl_d = lvl_q;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = '0;
      if (s2[i] != lvl_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          lvl_d[i] = s2[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= cnt_d[i];
    end
  end
`else
  assign lvl_d = s2;
`endif

  // Events are derived from the level about to be registered, so STATUS sets with lvl_q.
  assign set_evt  = (lvl_d & ~lvl_q & ~edge_sel_q) | (~lvl_d & lvl_q & edge_sel_q);
  assign clr_mask = (we && (addr == ADDR_STATUS)) ? wdata : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lvl_q      <= '0;
      status_q   <= '0;
      irq_en_q   <= '0;
      edge_sel_q <= '0;
    end else begin
      lvl_q    <= lvl_d;
      status_q <= (status_q & ~clr_mask) | set_evt;
      if (we && (addr == ADDR_IRQ_EN))   irq_en_q   <= wdata;
      if (we && (addr == ADDR_EDGE_SEL)) edge_sel_q <= wdata;
    end
  end

  always_comb begin
    rd_mux = '0;
    case (addr)
      ADDR_DATA:     rd_mux = lvl_q;
      ADDR_STATUS:   rd_mux = status_q;
      ADDR_IRQ_EN:   rd_mux = irq_en_q;
      ADDR_EDGE_SEL: rd_mux = edge_sel_q;
      default:       rd_mux = '0;
    endcase
  end

  // Reads sample pre-write register values, giving read-before-write on a shared cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= rd_mux;
    end
  end

  assign irq = |(status_q & irq_en_q);

endmodule
